// File: rtl/motor_pwm_multi_pkg.sv
// Shared definitions for the multi-channel motor PWM block.
// Holds the controller state encoding and the default timing constants
// (50 MHz clock, ~7.3 kHz PWM, duty floor and per-period ramp limit).
package motor_pwm_multi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

    localparam int unsigned DEF_PERIOD    = 6826;
    localparam int unsigned DEF_OFFSET    = 2730;
    localparam int unsigned DEF_RAMP_STEP = 512;

endpackage

// File: rtl/motor_pwm_channel.sv
// One PWM channel: converts a duty request into a target, ramps the applied
// duty towards it once per period, and compares against the shared counter.
// Ports:
//   i_clk       - clock, rising edge
//   i_rst_n     - synchronous active-low reset
//   i_run_next  - controller will be in RUN next clock; low clears the channel
//   i_sample    - counter is at PERIOD-1 in RUN: latch input, update duty
//   i_cnt       - shared period counter
//   i_duty      - raw duty request
//   o_pwm       - registered PWM output
//   o_ramping   - applied duty still below the sampled target
module motor_pwm_channel
    import motor_pwm_multi_pkg::*;
#(
    parameter int unsigned IN_W      = 12,
    parameter int unsigned CNT_W     = 13,
    parameter int unsigned PERIOD    = DEF_PERIOD,
    parameter int unsigned OFFSET    = DEF_OFFSET,
    parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run_next,
    input  logic             i_sample,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [IN_W-1:0]  i_duty,
    output logic             o_pwm,
    output logic             o_ramping
);

    // One extra bit so input+OFFSET and applied+RAMP_STEP cannot wrap.
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] r_applied;
    logic [CNT_W-1:0] r_target;
    logic             r_pwm;

    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_ramp;
    logic [CNT_W-1:0] w_target;
    logic [CNT_W-1:0] w_applied_next;

    always_comb begin
        w_sum = SUM_W'(i_duty) + SUM_W'(OFFSET);
        if (i_duty == '0) begin
            w_target = '0;
        end else if (w_sum > SUM_W'(PERIOD)) begin
            w_target = CNT_W'(PERIOD);
        end else begin
            w_target = w_sum[CNT_W-1:0];
        end
    end

    // Falling targets apply at once; rising ones are rate-limited.
    always_comb begin
        w_ramp         = {1'b0, r_applied} + SUM_W'(RAMP_STEP);
        w_applied_next = r_applied;
        if (w_target < r_applied) begin
            w_applied_next = w_target;
        end else if (w_target > r_applied) begin
            if (w_ramp > {1'b0, w_target}) begin
                w_applied_next = w_target;
            end else begin
                w_applied_next = w_ramp[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_run_next) begin
            r_applied <= '0;
            r_target  <= '0;
            r_pwm     <= 1'b0;
        end else begin
            if (i_sample) begin
                r_applied <= w_applied_next;
                r_target  <= w_target;
            end
            r_pwm <= (i_cnt < r_applied);
        end
    end

    assign o_pwm     = r_pwm;
    assign o_ramping = (r_applied < r_target);

endmodule

// File: rtl/motor_pwm_multi.sv
// Multi-channel motor PWM generator with duty floor and soft-start ramp.
// Owns the IDLE/RUN controller, the shared period counter and PeriodStart;
// per-channel duty handling lives in motor_pwm_channel.
// Ports:
//   PWMClock    - 50 MHz clock, rising edge
//   PWMReset_n  - synchronous active-low reset
//   PWMenable   - global run enable
//   PWMinput    - CHANNELS packed duty requests, channel k at [k*IN_W +: IN_W]
//   PWMout      - registered PWM outputs
//   PeriodStart - one-clock pulse with the output cycle for counter 0
//   Ramping     - per channel, applied duty below target
module motor_pwm_multi
    import motor_pwm_multi_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned IN_W      = 12,
    parameter int unsigned CNT_W     = 13,
    parameter int unsigned PERIOD    = DEF_PERIOD,
    parameter int unsigned OFFSET    = DEF_OFFSET,
    parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic                     PWMClock,
    input  logic                     PWMReset_n,
    input  logic                     PWMenable,
    input  logic [CHANNELS*IN_W-1:0] PWMinput,
    output logic [CHANNELS-1:0]      PWMout,
    output logic                     PeriodStart,
    output logic [CHANNELS-1:0]      Ramping
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    pwm_state_e       r_state;
    pwm_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_period_start;
    logic             w_run_next;
    logic             w_sample;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (PWMenable)  w_state_next = RUN;
            RUN:  if (!PWMenable) w_state_next = IDLE;
        endcase

        w_run_next = (w_state_next == RUN);
        w_sample   = (r_state == RUN) && (r_cnt == LAST);

        // Counter only advances while staying in RUN, so the first RUN
        // cycle always sees counter 0.
        w_cnt_next = '0;
        if ((r_state == RUN) && w_run_next && (r_cnt != LAST)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge PWMClock) begin
        if (!PWMReset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            // Registered like PWMout, so it lines up with the counter-0 output.
            r_period_start <= w_run_next && (r_state == RUN) && (r_cnt == '0);
        end
    end

    assign PeriodStart = r_period_start;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        motor_pwm_channel #(
            .IN_W      (IN_W),
            .CNT_W     (CNT_W),
            .PERIOD    (PERIOD),
            .OFFSET    (OFFSET),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .i_clk      (PWMClock),
            .i_rst_n    (PWMReset_n),
            .i_run_next (w_run_next),
            .i_sample   (w_sample),
            .i_cnt      (r_cnt),
            .i_duty     (PWMinput[g*IN_W +: IN_W]),
            .o_pwm      (PWMout[g]),
            .o_ramping  (Ramping[g])
        );
    end

endmodule

// File: tb/tb_motor_pwm_multi.sv
// Directed bench for motor_pwm_multi. dut_a is a scaled-down two-channel
// instance (PERIOD 200, OFFSET 80, RAMP_STEP 16) for ramp, enable, reset and
// mid-period behaviour; dut_b uses full-size defaults with RAMP_STEP=PERIOD.
module tb_motor_pwm_multi;

    localparam int PA = 200;
    localparam int OA = 80;
    localparam int RA = 16;
    localparam int PB = 6826;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, ps_a;
    logic [15:0] in_a;
    logic [1:0]  pwm_a, ramp_a;

    logic        rst_b, en_b, ps_b, pwm_b, ramp_b;
    logic [11:0] in_b;

    int errors = 0;
    int checks = 0;
    int mdl_app[2];
    int mdl_tgt[2];

    motor_pwm_multi #(
        .CHANNELS (2),
        .IN_W     (8),
        .CNT_W    (9),
        .PERIOD   (PA),
        .OFFSET   (OA),
        .RAMP_STEP(RA)
    ) dut_a (
        .PWMClock   (clk),
        .PWMReset_n (rst_a),
        .PWMenable  (en_a),
        .PWMinput   (in_a),
        .PWMout     (pwm_a),
        .PeriodStart(ps_a),
        .Ramping    (ramp_a)
    );

    motor_pwm_multi #(
        .CHANNELS (1),
        .RAMP_STEP(PB)
    ) dut_b (
        .PWMClock   (clk),
        .PWMReset_n (rst_b),
        .PWMenable  (en_b),
        .PWMinput   (in_b),
        .PWMout     (pwm_b),
        .PeriodStart(ps_b),
        .Ramping    (ramp_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int tgt_a(input int din);
        if (din == 0) return 0;
        return (din + OA > PA) ? PA : din + OA;
    endfunction

    function automatic int step_a(input int app, input int tgt);
        if (tgt < app) return tgt;
        if (tgt > app) return (app + RA > tgt) ? tgt : app + RA;
        return app;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            mdl_app[k] = 0;
            mdl_tgt[k] = 0;
        end
    endtask

    task automatic wait_ps_a(input string tag);
        int n = 0;
        while (ps_a !== 1'b1 && n < 2 * PA) begin
            tick();
            n++;
        end
        chk(tag, int'(ps_a), 1);
    endtask

    // Measures one dut_a period starting at PeriodStart; optionally changes
    // the input mid-period, then advances the model with the sampled input.
    task automatic period_a(input string tag, input int chg_at, input logic [15:0] chg_val);
        int hi0 = 0;
        int hi1 = 0;
        int psn = 0;
        int t;
        wait_ps_a({tag, "_ps"});
        chk({tag, "_ramp0"}, int'(ramp_a[0]), int'(mdl_tgt[0] > mdl_app[0]));
        chk({tag, "_ramp1"}, int'(ramp_a[1]), int'(mdl_tgt[1] > mdl_app[1]));
        for (int i = 0; i < PA; i++) begin
            if (i == chg_at) in_a = chg_val;
            hi0 += int'(pwm_a[0]);
            hi1 += int'(pwm_a[1]);
            psn += int'(ps_a);
            tick();
        end
        chk({tag, "_hi0"}, hi0, mdl_app[0]);
        chk({tag, "_hi1"}, hi1, mdl_app[1]);
        chk({tag, "_psn"}, psn, 1);
        chk({tag, "_psnext"}, int'(ps_a), 1);
        for (int k = 0; k < 2; k++) begin
            t = tgt_a(int'(in_a[k*8 +: 8]));
            mdl_app[k] = step_a(mdl_app[k], t);
            mdl_tgt[k] = t;
        end
    endtask

    task automatic period_b(input string tag, input int exp_hi);
        int hi = 0;
        int lo = 0;
        int n = 0;
        while (ps_b !== 1'b1 && n < 2 * PB) begin
            tick();
            n++;
        end
        chk({tag, "_ps"}, int'(ps_b), 1);
        for (int i = 0; i < PB; i++) begin
            if (pwm_b === 1'b1) hi++;
            else lo++;
            tick();
        end
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, PB - exp_hi);
        chk({tag, "_psnext"}, int'(ps_b), 1);
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b0; in_a = '0;
        rst_b = 1'b0; en_b = 1'b0; in_b = '0;
        repeat (3) tick();
        chk("rst_pwm_a", int'(pwm_a), 0);
        chk("rst_ps_a", int'(ps_a), 0);
        chk("rst_ramp_a", int'(ramp_a), 0);
        chk("rst_pwm_b", int'(pwm_b), 0);
        chk("rst_ps_b", int'(ps_b), 0);
        chk("rst_ramp_b", int'(ramp_b), 0);

        // Ramp from 0: ch0 towards 199 (PERIOD-1), ch1 saturates at PERIOD.
        clear_model();
        in_a  = {8'd255, 8'd119};
        rst_a = 1'b1;
        en_a  = 1'b1;
        for (int p = 0; p < 14; p++) period_a($sformatf("ramp_p%0d", p), -1, in_a);

        // Drop enable at counter 150 while both outputs are high.
        wait_ps_a("drop_ps");
        repeat (149) tick();
        chk("drop_pre", int'(pwm_a), 3);
        en_a = 1'b0;
        tick();
        chk("drop_pwm", int'(pwm_a), 0);
        chk("drop_psout", int'(ps_a), 0);
        chk("drop_ramp", int'(ramp_a), 0);
        repeat (5) tick();
        chk("idle_pwm", int'(pwm_a), 0);
        clear_model();
        en_a = 1'b1;
        for (int p = 0; p < 14; p++) period_a($sformatf("reen_p%0d", p), -1, in_a);

        // ch0 request cleared mid-period: current period intact, then low.
        period_a("zero_mid", 50, {8'd255, 8'd0});
        period_a("zero_next", -1, in_a);

        // Different requests, then a one-clock reset in the middle of a ramp.
        in_a = {8'd50, 8'd119};
        for (int p = 0; p < 3; p++) period_a($sformatf("diff_p%0d", p), -1, in_a);
        wait_ps_a("mrst_ps");
        repeat (29) tick();
        chk("mrst_pre_pwm", int'(pwm_a), 3);
        chk("mrst_pre_ramp", int'(ramp_a), 1);
        rst_a = 1'b0;
        tick();
        chk("mrst_pwm", int'(pwm_a), 0);
        chk("mrst_psout", int'(ps_a), 0);
        chk("mrst_ramp", int'(ramp_a), 0);
        rst_a = 1'b1;
        clear_model();
        for (int p = 0; p < 14; p++) period_a($sformatf("indep_p%0d", p), -1, in_a);

        // Full-size instance: one-period ramp to 1000+2730.
        in_b  = 12'd1000;
        rst_b = 1'b1;
        en_b  = 1'b1;
        period_b("b_p0", 0);
        period_b("b_p1", 3730);
        period_b("b_p2", 3730);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
